display_timing_gen: RTL and testbench
=====================================

# display_timing_gen

Downstream output stage of the display adapter. Consumes the 8-bit pixel stream selected by the frame multiplexer and produces raster timing: horizontal/vertical sync, data-enable and a registered pixel output. Pulls pixels from the datapath with a ready/valid handshake during the active region only, and flags starvation. Sits between the datapath's frame output and the physical display pins.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  run raster; 0 holds generator idle
- PxIn  in  8  pixel byte from frame multiplexer
- PxValid  in  1  PxIn holds a valid pixel
- PxReady  out  1  generator consumes PxIn this cycle
- HSync  out  1  horizontal sync, polarity per SYNC_POL
- VSync  out  1  vertical sync, polarity per SYNC_POL
- DE  out  1  active-video data enable
- PxOut  out  8  registered pixel to display
- FrameStart  out  1  one-cycle pulse, first pixel of frame
- LineStart  out  1  one-cycle pulse, first pixel of each line
- Underflow  out  1  sticky: active pixel requested with PxValid=0
- HCount  out  10  current horizontal counter
- VCount  out  10  current vertical counter

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise; both ≤ 1024 (10-bit counters); violating parameters are an elaboration error.
- HCount runs 0..H_TOTAL-1, wraps to 0; VCount increments on HCount wrap, wraps 0 after V_TOTAL-1.
- Active region: HCount < H_ACTIVE and VCount < V_ACTIVE.
- PxReady = enable & active (combinational from counter registers). A pixel is consumed only when PxReady & PxValid.
- Active cycle with PxValid=1: PxOut <= PxIn, DE <= 1.
- Active cycle with PxValid=0: PxOut <= 0, DE <= 1, Underflow <= 1; raster timing never stalls.
- Blanking cycles: PxOut <= 0, DE <= 0; PxValid ignored.
- HSync active when H_ACTIVE+H_FP ≤ HCount < H_ACTIVE+H_FP+H_SYNC; VSync active when V_ACTIVE+V_FP ≤ VCount < V_ACTIVE+V_FP+V_SYNC (full lines).
- FrameStart when counters are (0,0); LineStart when HCount=0 and VCount < V_ACTIVE.
- enable=0: counters load 0 next edge; outputs idle (sync inactive, DE=0, PxOut=0, pulses 0). Re-enable starts a fresh frame at (0,0); a partial frame is never resumed.
- Underflow clears only on reset.

## Timing
- Reset values: HCount=0, VCount=0, HSync=VSync=~SYNC_POL, DE=0, PxOut=0, FrameStart=0, LineStart=0, Underflow=0.
- Latency: HSync/VSync/DE/PxOut/FrameStart/LineStart are registered, one cycle after the counter state that produced them; PxReady is zero-latency.
- First edge after reset release with enable=1: counter at (0,0), PxReady=1; FrameStart=1 on the following cycle along with first DE.
- reset has priority over enable; reset mid-frame returns all state to reset values at that edge.
- Counter wrap (H_TOTAL-1, V_TOTAL-1) -> (0,0) in one edge; no idle cycle between frames.

## Structure
- Package display_timing_pkg: default VGA 640x480 timing constants, counter width constant (10), sync-polarity constant.
- One sub-module hv_counter: HCount/VCount with wrap and clear; top adds region decode, handshake and output registers.

## Test plan
Bench uses H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8), V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6), SYNC_POL=0.
- Reset then enable, PxValid=1, PxIn incrementing from 0x10 -> 4 DE cycles per line, PxOut 0x10..0x13 on line 0; 12 pixels per frame; frame repeats every 48 cycles.
- Same run -> HSync low for counter states HCount 5..6 (observed one cycle later); VSync low for all 8 cycles of VCount=4; FrameStart once per 48 cycles.
- PxValid=0 for the pixel at HCount=2, VCount=1 -> PxOut=0 with DE=1 that cycle; Underflow=1 and remains 1 through following frames.
- PxValid=1 constantly -> PxReady=0 on all 36 blanking cycles per frame; no pixel consumed during blanking.
- Drop enable at HCount=3, VCount=2 -> next cycle counters 0, DE=0, syncs high; re-enable -> FrameStart one cycle after counters restart at (0,0).
- Assert reset mid-frame with Underflow=1 -> all outputs at reset values on the next edge, Underflow=0.

Source files
------------

// File: rtl/display_timing_pkg.sv
// Shared timing constants and helpers for the display output stage.
// Defaults describe 640x480 VGA raster timing.
package display_timing_pkg;

   localparam int CNT_W     = 10;
   localparam int CNT_RANGE = 1 << CNT_W;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam logic DEF_SYNC_POL = 1'b0;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
      logic frame_start;
      logic line_start;
   } region_t;

   function automatic logic in_window(input int val, input int lo, input int hi);
      return (val >= lo) && (val < hi);
   endfunction

endpackage

// File: rtl/hv_counter.sv
// Raster position counters: HCount runs across the line, VCount steps on
// each line wrap; both return to zero together at the end of a frame.
module hv_counter
   import display_timing_pkg::*;
#(
   parameter int H_TOTAL = 800,
   parameter int V_TOTAL = 525
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   output cnt_t hcount_o,
   output cnt_t vcount_o
);

   localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

   cnt_t h_q, h_d;
   cnt_t v_q, v_d;

   always_comb begin
      // NOTE: defaults first so every path assigns h_d/v_d and no latch is inferred.
      h_d = h_q;
      v_d = v_q;
      if (clear_i) begin
         h_d = '0;
         v_d = '0;
      end else if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
         h_d = h_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign hcount_o = h_q;
   assign vcount_o = v_q;

endmodule

// File: rtl/display_timing_gen.sv
// Raster timing generator: decodes the counter position into sync/active
// regions, pulls pixels during active video and registers all display outputs.
module display_timing_gen
   import display_timing_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = DEF_SYNC_POL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [7:0]       PxIn,
   input  logic             PxValid,
   output logic             PxReady,
   output logic             HSync,
   output logic             VSync,
   output logic             DE,
   output logic [7:0]       PxOut,
   output logic             FrameStart,
   output logic             LineStart,
   output logic             Underflow,
   output logic [CNT_W-1:0] HCount,
   output logic [CNT_W-1:0] VCount
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > CNT_RANGE) begin : g_h_total_err
      $error("display_timing_gen: H_TOTAL %0d exceeds counter range %0d", H_TOTAL, CNT_RANGE);
   end
   if (V_TOTAL > CNT_RANGE) begin : g_v_total_err
      $error("display_timing_gen: V_TOTAL %0d exceeds counter range %0d", V_TOTAL, CNT_RANGE);
   end

   cnt_t    hcount, vcount;
   region_t region;

   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       de_q, de_d;
   logic [7:0] px_q, px_d;
   logic       frame_start_q, frame_start_d;
   logic       line_start_q, line_start_d;
   logic       underflow_q, underflow_d;

   hv_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_hv_counter (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (~enable),
      .hcount_o (hcount),
      .vcount_o (vcount)
   );

   always_comb begin
      region.active      = (int'(hcount) < H_ACTIVE) && (int'(vcount) < V_ACTIVE);
      region.hsync       = in_window(int'(hcount), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
      region.vsync       = in_window(int'(vcount), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
      region.frame_start = (hcount == '0) && (vcount == '0);
      region.line_start  = (hcount == '0) && (int'(vcount) < V_ACTIVE);
   end

   assign PxReady = enable & region.active;

   // Timing never stalls: a missing pixel still produces a DE cycle, blanked to 0.
   always_comb begin
      de_d          = PxReady;
      px_d          = (PxReady && PxValid) ? PxIn : 8'h00;
      hsync_d       = (enable && region.hsync) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (enable && region.vsync) ? SYNC_POL : ~SYNC_POL;
      frame_start_d = enable & region.frame_start;
      line_start_d  = enable & region.line_start;
      underflow_d   = underflow_q | (PxReady & ~PxValid);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         de_q          <= 1'b0;
         px_q          <= 8'h00;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         px_q          <= px_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
         underflow_q   <= underflow_d;
      end
   end

   assign HSync      = hsync_q;
   assign VSync      = vsync_q;
   assign DE         = de_q;
   assign PxOut      = px_q;
   assign FrameStart = frame_start_q;
   assign LineStart  = line_start_q;
   assign Underflow  = underflow_q;
   assign HCount     = hcount;
   assign VCount     = vcount;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen on a tiny 8x6 raster; the reference model tracks
// a linear position within the 48-cycle frame and derives everything from it.
module tb_display_timing_gen;

   localparam int HA = 4, HF = 1, HS = 2, HB = 1;
   localparam int VA = 3, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [7:0] PxIn;
   logic       PxValid;
   logic       PxReady;
   logic       HSync;
   logic       VSync;
   logic       DE;
   logic [7:0] PxOut;
   logic       FrameStart;
   logic       LineStart;
   logic       Underflow;
   logic [9:0] HCount;
   logic [9:0] VCount;

   display_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .SYNC_POL (1'b0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .PxIn       (PxIn),
      .PxValid    (PxValid),
      .PxReady    (PxReady),
      .HSync      (HSync),
      .VSync      (VSync),
      .DE         (DE),
      .PxOut      (PxOut),
      .FrameStart (FrameStart),
      .LineStart  (LineStart),
      .Underflow  (Underflow),
      .HCount     (HCount),
      .VCount     (VCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: position within the frame plus sticky underflow.
   int   m_pos   = 0;
   bit   m_known = 1'b0;
   bit   m_uf    = 1'b0;
   bit   last_ready;
   logic e_de, e_hs, e_vs, e_fs, e_ls, e_uf;
   logic [7:0] e_px;

   typedef struct {
      logic       rst, en, vld;
      logic [7:0] px;
      logic       de;
      logic [7:0] pxo;
      logic       fs, ls, hs, vs;
      logic [9:0] hc, vc;
   } vec_t;

   vec_t tbl[11];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input logic r, input logic e, input logic v, input logic [7:0] d);
      int   h, ln;
      logic act;
      reset   = r;
      enable  = e;
      PxValid = v;
      PxIn    = d;
      #1;
      h  = m_pos % HT;
      ln = m_pos / HT;
      act = e && (h < HA) && (ln < VA);
      last_ready = act;
      if (m_known) begin
         check("pxready", int'(PxReady), int'(act));
         check("hcount", int'(HCount), h);
         check("vcount", int'(VCount), ln);
      end
      if (r) begin
         e_de = 1'b0; e_px = 8'h00; e_hs = 1'b1; e_vs = 1'b1;
         e_fs = 1'b0; e_ls = 1'b0;
         m_uf = 1'b0; m_pos = 0; m_known = 1'b1;
      end else begin
         e_de = act;
         e_px = (act && v) ? d : 8'h00;
         e_hs = !(e && h >= HA + HF && h < HA + HF + HS);
         e_vs = !(e && ln >= VA + VF && ln < VA + VF + VS);
         e_fs = e && (m_pos == 0);
         e_ls = e && (h == 0) && (ln < VA);
         if (act && !v) m_uf = 1'b1;
         m_pos = e ? (m_pos + 1) % FT : 0;
      end
      e_uf = m_uf;
      @(posedge clk);
      #1;
      if (m_known) begin
         check("de", int'(DE), int'(e_de));
         check("pxout", int'(PxOut), int'(e_px));
         check("hsync", int'(HSync), int'(e_hs));
         check("vsync", int'(VSync), int'(e_vs));
         check("framestart", int'(FrameStart), int'(e_fs));
         check("linestart", int'(LineStart), int'(e_ls));
         check("underflow", int'(Underflow), int'(e_uf));
      end
   endtask

   initial begin
      int de_cnt, fs_cnt, hs_lo, vs_lo, rdy_cnt, last_fs, px_ctr;

      reset = 1'b1; enable = 1'b0; PxValid = 1'b0; PxIn = 8'h00;

      // rst en vld px | de pxo fs ls hs vs | hc vc (counters after the edge)
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 10'd1, 10'd0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 10'd2, 10'd0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h12, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 10'd3, 10'd0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h13, 1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b1, 10'd4, 10'd0};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 10'd5, 10'd0};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'd6, 10'd0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'd7, 10'd0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd1};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h14, 1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 1'b1, 10'd1, 10'd1};

      for (int i = 0; i < 11; i++) begin
         tick(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].px);
         check("tbl_de", int'(DE), int'(tbl[i].de));
         check("tbl_pxout", int'(PxOut), int'(tbl[i].pxo));
         check("tbl_fs", int'(FrameStart), int'(tbl[i].fs));
         check("tbl_ls", int'(LineStart), int'(tbl[i].ls));
         check("tbl_hsync", int'(HSync), int'(tbl[i].hs));
         check("tbl_vsync", int'(VSync), int'(tbl[i].vs));
         check("tbl_hcount", int'(HCount), int'(tbl[i].hc));
         check("tbl_vcount", int'(VCount), int'(tbl[i].vc));
      end

      // Two full frames with a continuously valid source.
      tick(1'b1, 1'b1, 1'b1, 8'h00);
      de_cnt = 0; fs_cnt = 0; hs_lo = 0; vs_lo = 0; rdy_cnt = 0; last_fs = -1; px_ctr = 8'h10;
      for (int c = 0; c < 2 * FT; c++) begin
         tick(1'b0, 1'b1, 1'b1, 8'(px_ctr));
         if (last_ready) px_ctr++;
         if (PxReady === 1'b1 || last_ready) rdy_cnt += int'(last_ready);
         de_cnt += int'(DE);
         hs_lo  += int'(!HSync);
         vs_lo  += int'(!VSync);
         if (FrameStart) begin
            fs_cnt++;
            if (last_fs >= 0) check("fs_period", c - last_fs, FT);
            last_fs = c;
         end
      end
      check("frame_de_count", de_cnt, 2 * HA * VA);
      check("frame_fs_count", fs_cnt, 2);
      check("frame_hsync_low", hs_lo, 2 * HS * VT);
      check("frame_vsync_low", vs_lo, 2 * VS * HT);
      check("frame_consumed", rdy_cnt, 2 * HA * VA);

      // Starve the pixel at HCount=2, VCount=1.
      tick(1'b1, 1'b1, 1'b1, 8'h00);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1, 8'(8'h20 + i));
      tick(1'b0, 1'b1, 1'b0, 8'h55);
      check("starve_de", int'(DE), 1);
      check("starve_pxout", int'(PxOut), 0);
      check("starve_underflow", int'(Underflow), 1);
      for (int i = 0; i < 60; i++) tick(1'b0, 1'b1, 1'b1, 8'($urandom));
      check("underflow_sticky", int'(Underflow), 1);

      // Drop enable at HCount=3, VCount=2, then restart.
      for (int i = 0; i < FT && m_pos != 2 * HT + 3; i++) tick(1'b0, 1'b1, 1'b1, 8'($urandom));
      check("drop_at_h", int'(HCount), 3);
      check("drop_at_v", int'(VCount), 2);
      tick(1'b0, 1'b0, 1'b1, 8'h77);
      check("drop_hcount", int'(HCount), 0);
      check("drop_vcount", int'(VCount), 0);
      check("drop_de", int'(DE), 0);
      check("drop_hsync", int'(HSync), 1);
      check("drop_vsync", int'(VSync), 1);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 8'h77);
      tick(1'b0, 1'b1, 1'b1, 8'h31);
      check("restart_fs", int'(FrameStart), 1);
      check("restart_pxout", int'(PxOut), 8'h31);

      // Reset mid-frame while Underflow is set.
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b1, 8'($urandom));
      check("pre_reset_underflow", int'(Underflow), 1);
      tick(1'b1, 1'b1, 1'b1, 8'h99);
      check("reset_underflow", int'(Underflow), 0);
      check("reset_de", int'(DE), 0);
      check("reset_pxout", int'(PxOut), 0);
      check("reset_hcount", int'(HCount), 0);
      check("reset_vcount", int'(VCount), 0);

      // Randomised traffic against the model.
      for (int i = 0; i < 700; i++) begin
         tick(1'($urandom_range(0, 199) == 0),
              1'($urandom_range(0, 63) != 0),
              1'($urandom_range(0, 7) != 0),
              8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
